fm_demod: RTL and testbench



---
 rtl/fm_demod.sv | 216 +++++++++++++++++++++
 tb/tb_fm_demod.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_demod.sv
// fm_demod: quadrature-discriminator FM receiver.
//
// Recovers audio from complex baseband I/Q by cross-multiplying each sample
// with its predecessor (prev_i*cur_q - prev_q*cur_i), then applies a signed
// gain with saturation and a magnitude squelch with hysteresis.
//
// Ports:
//   i_clk, i_reset_n     clock, asynchronous active-low reset
//   i_ce, i_i, i_q       input sample strobe and signed I/Q sample
//   i_wb_*               Wishbone slave (cyc, stb, we, addr, data, sel)
//   o_wb_stall/ack/data  Wishbone response (stall tied low, ack one clock later)
//   o_ce, o_audio        audio strobe (4 clocks after i_ce) and signed audio
//   o_sq_open            squelch state (1 = open)
//
// Register map: 0 CONTROL {flush[31], sq_en[30], gain[15:0]},
//               1 THRESH, 2 STATUS {open, sat sticky, audio}, 3 DISC.
//
// Bus handshake: there is no backpressure. Every cycle with i_wb_stb high is
// a complete transfer (i_wb_cyc is not qualified); o_wb_ack follows one clock
// later with registered read data.
module fm_demod #(
    parameter int IW        = 12,
    parameter int OW        = 16,
    parameter int GAIN_BITS = 16,
    parameter int SHIFT     = 4,
    parameter int SQ_COUNT  = 16
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic [IW-1:0] i_i,
    input  logic [IW-1:0] i_q,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [1:0]    i_wb_addr,
    input  logic [31:0]   i_wb_data,
    input  logic [3:0]    i_wb_sel,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic [31:0]   o_wb_data,
    output logic          o_ce,
    output logic [OW-1:0] o_audio,
    output logic          o_sq_open
);
    localparam int MW = 2*IW + 1;           // exact product / discriminator width
    localparam int PW = MW + GAIN_BITS;     // gain product width
    localparam int SH = PW - OW - SHIFT;    // right shift before saturation
    localparam int CW = (SQ_COUNT > 1) ? $clog2(SQ_COUNT) : 1;
    localparam logic signed [PW-1:0] MAXV = (PW'(1) <<< (OW-1)) - PW'(1);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    typedef enum logic {SQ_CLOSED = 1'b0, SQ_OPEN = 1'b1} sq_state_t;

    logic signed [IW-1:0]        r_cur_i, r_cur_q, r_prev_i, r_prev_q;
    logic                        r_v1, r_v2, r_v3;
    logic signed [MW-1:0]        r_p1, r_p2, r_disc;
    logic        [MW-1:0]        r_mag2, r_mag3;
    logic signed [GAIN_BITS-1:0] r_gain;
    logic                        r_sq_en;
    logic        [MW-1:0]        r_thresh;
    logic                        r_sat;
    sq_state_t                   r_sq_state, w_sq_next;
    logic        [CW-1:0]        r_sq_cnt, w_sq_cnt_next;

    logic                        w_wr, w_rd, w_flush;
    logic signed [MW-1:0]        w_p1, w_p2, w_mag;
    logic signed [PW-1:0]        w_prod, w_shift;
    logic                        w_hi, w_lo, w_sat, w_mag_ok, w_toward;
    logic        [OW-1:0]        w_audio_sat;
    logic        [31:0]          w_rdata;
    logic        [15:0]          w_gain_rd, w_audio_rd;
    logic                        w_unused;

    assign w_unused   = ^{i_wb_cyc, i_wb_sel, i_wb_data};
    assign o_wb_stall = 1'b0;
    assign o_sq_open  = (r_sq_state == SQ_OPEN);

    assign w_wr    = i_wb_stb & i_wb_we;
    assign w_rd    = i_wb_stb & ~i_wb_we;
    assign w_flush = w_wr & (i_wb_addr == 2'd0) & i_wb_data[31];

    // S2 arithmetic: exact signed products, sign-extended before multiplying.
    assign w_p1  = MW'(r_prev_i) * MW'(r_cur_q);
    assign w_p2  = MW'(r_prev_q) * MW'(r_cur_i);
    assign w_mag = MW'(r_cur_i) * MW'(r_cur_i) + MW'(r_cur_q) * MW'(r_cur_q);

    // S4 arithmetic: arithmetic shift floors toward minus infinity.
    assign w_prod      = PW'(r_disc) * PW'(r_gain);
    assign w_shift     = w_prod >>> SH;
    assign w_hi        = (w_shift > MAXV);
    assign w_lo        = (w_shift < MINV);
    assign w_sat       = w_hi | w_lo;
    assign w_audio_sat = w_hi ? MAXV[OW-1:0] : (w_lo ? MINV[OW-1:0] : w_shift[OW-1:0]);

    assign w_mag_ok = (r_mag3 >= r_thresh);
    // A sample counts toward a transition when it disagrees with the current state.
    assign w_toward = (r_sq_state == SQ_CLOSED) ? w_mag_ok : ~w_mag_ok;

    // Pipeline stages S1..S3. A flush kills every in-flight sample, including
    // one arriving in the same cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
            r_cur_i <= '0; r_cur_q <= '0; r_prev_i <= '0; r_prev_q <= '0;
            r_p1 <= '0; r_p2 <= '0; r_mag2 <= '0;
            r_disc <= '0; r_mag3 <= '0;
        end else begin
            r_v1 <= i_ce & ~w_flush;
            r_v2 <= r_v1 & ~w_flush;
            r_v3 <= r_v2 & ~w_flush;
            if (w_flush) begin
                r_cur_i <= '0; r_cur_q <= '0; r_prev_i <= '0; r_prev_q <= '0;
            end else if (i_ce) begin
                r_prev_i <= r_cur_i;
                r_prev_q <= r_cur_q;
                r_cur_i  <= i_i;
                r_cur_q  <= i_q;
            end
            if (r_v1) begin
                r_p1   <= w_p1;
                r_p2   <= w_p2;
                r_mag2 <= w_mag;
            end
            if (r_v2) begin
                r_disc <= r_p1 - r_p2;
                r_mag3 <= r_mag2;
            end
        end
    end

    // Squelch FSM: next state and hysteresis counter.
    always_comb begin
        w_sq_next     = r_sq_state;
        w_sq_cnt_next = r_sq_cnt;
        if (w_flush) begin
            w_sq_next     = SQ_CLOSED;
            w_sq_cnt_next = '0;
        end else if (!r_sq_en) begin
            w_sq_next     = SQ_OPEN;
            w_sq_cnt_next = '0;
        end else if (r_v3) begin
            if (w_toward) begin
                if (r_sq_cnt == CW'(SQ_COUNT - 1)) begin
                    w_sq_next     = (r_sq_state == SQ_CLOSED) ? SQ_OPEN : SQ_CLOSED;
                    w_sq_cnt_next = '0;
                end else begin
                    w_sq_cnt_next = r_sq_cnt + CW'(1);
                end
            end else begin
                w_sq_cnt_next = '0;
            end
        end
    end

    // S4 output stage, squelch state register and saturation sticky.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_ce       <= 1'b0;
            o_audio    <= '0;
            r_sq_state <= SQ_CLOSED;
            r_sq_cnt   <= '0;
            r_sat      <= 1'b0;
        end else begin
            o_ce       <= r_v3 & ~w_flush;
            r_sq_state <= w_sq_next;
            r_sq_cnt   <= w_sq_cnt_next;
            if (r_v3 && !w_flush)
                o_audio <= (w_sq_next == SQ_OPEN) ? w_audio_sat : '0;
            // A saturation in the same clock as the clearing read wins.
            if (r_v3 && !w_flush && w_sat)
                r_sat <= 1'b1;
            else if (w_rd && i_wb_addr == 2'd2)
                r_sat <= 1'b0;
        end
    end

    assign w_gain_rd  = 16'(r_gain);
    assign w_audio_rd = 16'($signed(o_audio));

    always_comb begin
        w_rdata = '0;
        case (i_wb_addr)
            2'd0: w_rdata = {1'b0, r_sq_en, 14'd0, w_gain_rd};
            2'd1: w_rdata = 32'(r_thresh);
            2'd2: w_rdata = {o_sq_open, r_sat, 14'd0, w_audio_rd};
            2'd3: w_rdata = 32'(r_disc);
            default: w_rdata = '0;
        endcase
    end

    // Register file and bus response.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
            r_gain    <= GAIN_BITS'(16'h0100);
            r_sq_en   <= 1'b0;
            r_thresh  <= '0;
        end else begin
            o_wb_ack <= i_wb_stb;
            if (w_rd)
                o_wb_data <= w_rdata;
            if (w_wr) begin
                case (i_wb_addr)
                    2'd0: begin
                        r_gain  <= i_wb_data[GAIN_BITS-1:0];
                        r_sq_en <= i_wb_data[30];
                    end
                    2'd1: r_thresh <= i_wb_data[MW-1:0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fm_demod.sv
module tb_fm_demod;
  localparam int IW = 12;
  localparam int OW = 16;
  localparam int EW = 49;  // {due_cycle[31:0], sq_open, audio[15:0]}
  localparam longint DIV = 64'sd2097152;  // 2^(2IW+1+GAIN_BITS-OW-SHIFT)

  logic clk, rst_n;
  logic ce;
  logic [IW-1:0] ii, qq;
  logic wb_stb, wb_we;
  logic [1:0] wb_addr;
  logic [31:0] wb_data;
  logic o_wb_stall, o_wb_ack, o_ce, o_sq_open;
  logic [31:0] o_wb_data;
  logic [OW-1:0] o_audio;

  int tests = 0;
  int fails = 0;

  fm_demod #(.IW(IW), .OW(OW), .GAIN_BITS(16), .SHIFT(4), .SQ_COUNT(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_i(ii), .i_q(qq),
    .i_wb_cyc(wb_stb), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr),
    .i_wb_data(wb_data), .i_wb_sel(4'hf),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .o_ce(o_ce), .o_audio(o_audio), .o_sq_open(o_sq_open)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: act=0x%08h exp=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int  n = 0;
  int  m_pi, m_pq, m_gain, m_thr, m_cnt;
  bit  m_sq_en, m_open, exp_ack;

  task automatic model_sample(input int si, input int sq);
    longint disc, p, a, mag;
    bit open;
    disc = longint'(m_pi) * sq - longint'(m_pq) * si;
    p = disc * m_gain;
    a = p / DIV;
    if (p < 0 && (p % DIV) != 0) a = a - 1;
    if (a > 32767) a = 32767;
    if (a < -32768) a = -32768;
    mag = longint'(si) * si + longint'(sq) * sq;
    if (m_sq_en) begin
      if ((!m_open && mag >= m_thr) || (m_open && mag < m_thr)) begin
        m_cnt++;
        if (m_cnt == 16) begin
          m_open = !m_open;
          m_cnt = 0;
        end
      end else begin
        m_cnt = 0;
      end
    end
    open = m_sq_en ? m_open : 1'b1;
    if (!open) a = 0;
    exp_q.push_back({32'(n + 3), open, 16'(a)});
    m_pi = si;
    m_pq = sq;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_pi = 0; m_pq = 0; m_gain = 256; m_thr = 0; m_cnt = 0;
      m_sq_en = 0; m_open = 0; exp_ack = 0;
    end else begin
      bit fl;
      n++;
      exp_ack = wb_stb;
      fl = wb_stb && wb_we && wb_addr == 2'd0 && wb_data[31];
      if (fl) begin
        exp_q.delete();
        m_pi = 0; m_pq = 0; m_open = 0; m_cnt = 0;
      end else if (!m_sq_en) begin
        m_open = 1; m_cnt = 0;
      end
      if (ce && !fl) model_sample(int'($signed(ii)), int'($signed(qq)));
      if (wb_stb && wb_we) begin
        if (wb_addr == 2'd0) begin
          m_gain = int'($signed(wb_data[15:0]));
          m_sq_en = wb_data[30];
        end else if (wb_addr == 2'd1) begin
          m_thr = int'(wb_data[24:0]);
        end
      end
    end
  end

  // One compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [EW-1:0] e;
      bit due;
      due = (exp_q.size() > 0) && (exp_q[0][48:17] == 32'(n));
      check("o_ce", 32'(o_ce), 32'(due));
      if (due) begin
        e = exp_q.pop_front();
        check("o_audio", 32'(o_audio), 32'(e[15:0]));
        check("o_sq_open", 32'(o_sq_open), 32'(e[16]));
      end
      check("o_wb_ack", 32'(o_wb_ack), 32'(exp_ack));
      check("o_wb_stall", 32'(o_wb_stall), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  int phase = 0;

  task automatic step(input logic c, input int si, input int sq, input logic stb,
                      input logic we, input logic [1:0] a, input logic [31:0] d);
    ce = c; ii = IW'(si); qq = IW'(sq);
    wb_stb = stb; wb_we = we; wb_addr = a; wb_data = d;
    @(posedge clk); #1;
    ce = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(0, 0, 0, 0, 0, 2'd0, 32'd0);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    step(0, 0, 0, 1, 1, a, d);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    step(0, 0, 0, 1, 0, a, 32'd0);
    d = o_wb_data;
  endtask

  // Rotating tone: dir=+1 advances +90 degrees per sample, dir=-1 reverses.
  task automatic tone_sample(input int amp, input int dir, output int si, output int sq);
    case (phase % 4)
      0: begin si = amp;  sq = 0; end
      1: begin si = 0;    sq = amp * dir; end
      2: begin si = -amp; sq = 0; end
      default: begin si = 0; sq = -amp * dir; end
    endcase
    phase++;
  endtask

  task automatic tone(input int amp, input int dir, input int count);
    int si, sq;
    for (int k = 0; k < count; k++) begin
      tone_sample(amp, dir, si, sq);
      step(1, si, sq, 0, 0, 2'd0, 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    int si, sq;
    rst_n = 1'b0; ce = 1'b0; ii = '0; qq = '0;
    wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset o_ce", 32'(o_ce), 32'd0);
    check("reset o_audio", 32'(o_audio), 32'd0);
    check("reset o_wb_ack", 32'(o_wb_ack), 32'd0);
    check("reset o_wb_data", o_wb_data, 32'd0);
    check("reset o_sq_open", 32'(o_sq_open), 32'd0);
    rst_n = 1'b1;
    idle(2);
    wb_read(2'd0, rd); check("reset CONTROL", rd, 32'h0000_0100);
    wb_read(2'd1, rd); check("reset THRESH", rd, 32'd0);

    // Latency of a single isolated sample: o_ce exactly 4 clocks later.
    step(1, 1000, 0, 0, 0, 2'd0, 32'd0);
    for (int k = 1; k < 4; k++) begin
      check("latency early o_ce", 32'(o_ce), 32'd0);
      idle(1);
    end
    check("latency o_ce", 32'(o_ce), 32'd1);
    idle(3);

    // Constant phase: zero audio.
    for (int k = 0; k < 12; k++) step(1, 1000, 0, 0, 0, 2'd0, 32'd0);
    idle(6);
    wb_read(2'd2, rd); check("const STATUS", rd, 32'h8000_0000);

    // +90 degrees per sample: disc 1e6, audio 122.
    phase = 0;
    tone(1000, 1, 12);
    idle(6);
    wb_read(2'd2, rd); check("fwd STATUS", rd, 32'h8000_007A);
    wb_read(2'd3, rd); check("fwd DISC", rd, 32'd1000000);

    // Reversed rotation: audio -123.
    phase = 0;
    tone(1000, -1, 12);
    idle(6);
    wb_read(2'd2, rd); check("rev STATUS", rd, 32'h8000_FF85);
    wb_read(2'd3, rd); check("rev DISC", rd, 32'hFFF0_BDC0);

    // Asynchronous reset in the middle of a stream.
    tone(1000, -1, 6);
    rst_n = 1'b0;
    #1;
    check("midreset o_ce", 32'(o_ce), 32'd0);
    check("midreset o_audio", 32'(o_audio), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    wb_read(2'd0, rd); check("midreset CONTROL", rd, 32'h0000_0100);
    step(1, 0, 1000, 0, 0, 2'd0, 32'd0);
    idle(6);
    wb_read(2'd2, rd); check("post-reset first audio", rd, 32'h8000_0000);

    // Saturation with full gain and amplitude 2000.
    wb_write(2'd0, 32'h0000_7FFF);
    phase = 0;
    tone(2000, 1, 8);
    idle(6);
    wb_read(2'd2, rd); check("sat STATUS", rd, 32'hC000_7FFF);
    wb_read(2'd2, rd); check("sat cleared STATUS", rd, 32'h8000_7FFF);

    // Squelch with hysteresis.
    wb_write(2'd1, 32'd2000000);
    wb_write(2'd0, 32'h4000_0100);
    wb_write(2'd0, 32'hC000_0100);
    check("flush closes squelch", 32'(o_sq_open), 32'd0);
    phase = 0;
    tone(1000, 1, 8);
    idle(6);
    wb_read(2'd2, rd); check("sq weak STATUS", rd, 32'h0000_0000);
    tone(2000, 1, 10);
    tone(1000, 1, 1);
    tone(2000, 1, 15);
    idle(6);
    wb_read(2'd2, rd); check("sq 15th STATUS", rd, 32'h0000_0000);
    tone(2000, 1, 1);
    idle(6);
    wb_read(2'd2, rd); check("sq 16th STATUS", rd, 32'h8000_01E8);

    // Flush together with a sample, mid-tone.
    tone(2000, 1, 6);
    tone_sample(2000, 1, si, sq);
    step(1, si, sq, 1, 1, 2'd0, 32'hC000_0100);
    check("flush+ce sq_open", 32'(o_sq_open), 32'd0);
    tone(2000, 1, 6);
    idle(6);
    wb_read(2'd2, rd); check("post-flush STATUS", rd, 32'h0000_0000);

    // Bus: write readback and back-to-back strobes.
    wb_write(2'd0, 32'h4000_0080);
    wb_read(2'd0, rd); check("b2b CONTROL", rd, 32'h4000_0080);
    check("b2b ack0", 32'(o_wb_ack), 32'd1);
    wb_read(2'd1, rd); check("b2b THRESH", rd, 32'd2000000);
    check("b2b ack1", 32'(o_wb_ack), 32'd1);
    wb_read(2'd2, rd);
    check("b2b ack2", 32'(o_wb_ack), 32'd1);
    wb_read(2'd3, rd);
    check("b2b ack3", 32'(o_wb_ack), 32'd1);
    check("b2b stall", 32'(o_wb_stall), 32'd0);
    idle(1);
    check("ack drops", 32'(o_wb_ack), 32'd0);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
